// File: rtl/top_level_pkg.sv
// Shared constants, register map, FSM state type and window-match helpers
// for the bit-pattern counting block.
package top_level_pkg;

  localparam int STR_BYTES = 32;
  localparam int MEM_DEPTH = 256;
  localparam int RF_DEPTH  = 8;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;

  localparam logic [ADDR_W-1:0] PAT_ADDR = 8'd32;
  localparam logic [ADDR_W-1:0] CTB_ADDR = 8'd33;
  localparam logic [ADDR_W-1:0] CTO_ADDR = 8'd34;
  localparam logic [ADDR_W-1:0] CTS_ADDR = 8'd35;

  localparam int R_PAT = 0;
  localparam int R_CTB = 1;
  localparam int R_CTO = 2;
  localparam int R_CTS = 3;
  localparam int R_IDX = 4;

  typedef enum logic [2:0] {
    IDLE,
    LDPAT,
    SCAN,
    WR_CTB,
    WR_CTO,
    WR_CTS,
    DONE
  } state_t;

  // Number of the four in-byte windows [7:3],[6:2],[5:1],[4:0] equal to p.
  function automatic logic [2:0] in_byte_hits(input logic [7:0] b,
                                              input logic [4:0] p);
    logic [2:0] hits;
    hits = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (b[7-k -: 5] == p) hits = hits + 3'd1;
    end
    return hits;
  endfunction

  // Number of the four windows straddling b0 -> b1 (b0 more significant)
  // equal to p: {b0[3:0],b1[7]} down to {b0[0],b1[7:4]}.
  function automatic logic [2:0] boundary_hits(input logic [7:0] b0,
                                               input logic [7:0] b1,
                                               input logic [4:0] p);
    logic [15:0] w;
    logic [2:0]  hits;
    w    = {b0, b1};
    hits = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (w[11-k -: 5] == p) hits = hits + 3'd1;
    end
    return hits;
  endfunction

endpackage

// File: rtl/top_level_if.sv
// Data-memory bus: two combinational read ports and one synchronous write port.
interface top_level_if;
  import top_level_pkg::*;

  logic [ADDR_W-1:0] ra0;
  logic [ADDR_W-1:0] ra1;
  logic [DATA_W-1:0] rd0;
  logic [DATA_W-1:0] rd1;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  modport master (output ra0, ra1, we, wa, wd, input rd0, rd1);
  modport slave  (input ra0, ra1, we, wa, wd, output rd0, rd1);
endinterface

// File: rtl/top_level_data_mem.sv
// Byte-wide data memory: two asynchronous reads, one clocked write, no reset
// so preloaded contents survive a reset.
module data_mem
  import top_level_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH
) (
  input logic        clk,
  top_level_if.slave bus
);

  logic [DATA_W-1:0] core [0:DEPTH-1];

  // Combinational read ports
  always_comb begin
    bus.rd0 = core[bus.ra0];
    bus.rd1 = core[bus.ra1];
  end

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (bus.we) core[bus.wa] <= bus.wd;
  end

endmodule

// File: rtl/top_level_reg_file.sv
// Eight 8-bit working registers with per-register write enables so the scan
// can update all counters and the index in the same cycle.
module reg_file
  import top_level_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic [RF_DEPTH-1:0]              we,
  input  logic [RF_DEPTH-1:0][DATA_W-1:0]  wd,
  output logic [RF_DEPTH-1:0][DATA_W-1:0]  q
);

  logic [DATA_W-1:0] core [0:RF_DEPTH-1];

  // Register update with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < RF_DEPTH; k++) core[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < RF_DEPTH; k++) begin
        if (we[k]) core[k] <= wd[k];
      end
    end
  end

  // Expose all registers as a flat read bus
  always_comb begin
    q = '0;
    for (int unsigned k = 0; k < RF_DEPTH; k++) q[k] = core[k];
  end

endmodule

// File: rtl/top_level.sv
// Counts occurrences of a 5-bit pattern in a 32-byte string held in data
// memory: in-byte windows (CTB), bytes with any in-byte hit (CTO) and all
// string windows including byte-boundary ones (CTS). Results go back to memory.
module top_level #(
  parameter int STR_BYTES = top_level_pkg::STR_BYTES,
  parameter int MEM_DEPTH = top_level_pkg::MEM_DEPTH
) (
  input  logic clk,
  input  logic reset,
  output logic done
);
  import top_level_pkg::*;

  state_t state;
  state_t next_state;

  top_level_if bus ();

  logic [RF_DEPTH-1:0]             rf_we;
  logic [RF_DEPTH-1:0][DATA_W-1:0] rf_wd;
  logic [RF_DEPTH-1:0][DATA_W-1:0] rf_q;

  data_mem #(.DEPTH(MEM_DEPTH)) dm1 (
    .clk (clk),
    .bus (bus.slave)
  );

  reg_file rf1 (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .wd    (rf_wd),
    .q     (rf_q)
  );

  logic [7:0] idx;
  logic [4:0] pat;
  logic       last_byte;
  logic [2:0] in_hits;
  logic [2:0] bnd_hits;
  logic [7:0] ctb_nxt;
  logic [7:0] cto_nxt;
  logic [7:0] cts_nxt;

  // Read addresses: pattern byte during LDPAT, otherwise bytes i and i+1
  always_comb begin
    idx     = rf_q[R_IDX];
    bus.ra0 = (state == LDPAT) ? PAT_ADDR : idx;
    bus.ra1 = idx + 8'd1;
  end

  // Window matcher and next counter values for the current byte pair
  always_comb begin
    pat       = rf_q[R_PAT][4:0];
    last_byte = (idx == 8'(STR_BYTES - 1));
    in_hits   = in_byte_hits(bus.rd0, pat);
    // The last string byte is followed by the pattern byte, not string data.
    bnd_hits  = last_byte ? 3'd0 : boundary_hits(bus.rd0, bus.rd1, pat);
    ctb_nxt   = rf_q[R_CTB] + 8'(in_hits);
    cto_nxt   = rf_q[R_CTO] + {7'b0, |in_hits};
    cts_nxt   = rf_q[R_CTS] + 8'(in_hits) + 8'(bnd_hits);
  end

  // State register and registered done flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (next_state == DONE);
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    next_state = LDPAT;
      LDPAT:   next_state = SCAN;
      SCAN:    next_state = last_byte ? WR_CTB : SCAN;
      WR_CTB:  next_state = WR_CTO;
      WR_CTO:  next_state = WR_CTS;
      WR_CTS:  next_state = DONE;
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath controls: register-file updates and result writes
  always_comb begin
    rf_we  = '0;
    rf_wd  = '0;
    bus.we = 1'b0;
    bus.wa = '0;
    bus.wd = '0;
    unique case (state)
      LDPAT: begin
        // Counters and index are cleared alongside the pattern load.
        rf_we[R_PAT] = 1'b1;
        rf_wd[R_PAT] = {3'b000, bus.rd0[7:3]};
        rf_we[R_CTB] = 1'b1;
        rf_we[R_CTO] = 1'b1;
        rf_we[R_CTS] = 1'b1;
        rf_we[R_IDX] = 1'b1;
      end
      SCAN: begin
        rf_we[R_CTB] = 1'b1;
        rf_wd[R_CTB] = ctb_nxt;
        rf_we[R_CTO] = 1'b1;
        rf_wd[R_CTO] = cto_nxt;
        rf_we[R_CTS] = 1'b1;
        rf_wd[R_CTS] = cts_nxt;
        rf_we[R_IDX] = 1'b1;
        rf_wd[R_IDX] = idx + 8'd1;
      end
      WR_CTB: begin
        bus.we = reset;
        bus.wa = CTB_ADDR;
        bus.wd = rf_q[R_CTB];
      end
      WR_CTO: begin
        bus.we = reset;
        bus.wa = CTO_ADDR;
        bus.wd = rf_q[R_CTO];
      end
      WR_CTS: begin
        bus.we = reset;
        bus.wa = CTS_ADDR;
        bus.wd = rf_q[R_CTS];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_top_level.sv
// Directed and random runs of the pattern counter with a bit-string model.
module tb_top_level;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic done;

  always #5 clk = ~clk;

  top_level #(.STR_BYTES(32), .MEM_DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] img [0:32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Slide a 5-bit window over the 256-bit string; a window is in-byte when
  // its top and bottom bits fall in the same byte.
  task automatic model(output int ctb, output int cto, output int cts);
    logic [255:0] s;
    logic [31:0]  hit;
    logic [4:0]   w;
    ctb = 0; cto = 0; cts = 0; hit = '0;
    for (int b = 0; b < 32; b++) s[255-8*b -: 8] = img[b];
    for (int j = 255; j >= 4; j--) begin
      w = s[j -: 5];
      if (w == img[32][7:3]) begin
        cts++;
        if (j / 8 == (j - 4) / 8) begin
          ctb++;
          hit[j/8] = 1'b1;
        end
      end
    end
    cto = $countones(hit);
  endtask

  task automatic load_and_reset();
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k <= 32; k++) dut.dm1.core[k] = img[k];
    for (int k = 33; k <= 35; k++) dut.dm1.core[k] = 8'hEE;
    @(negedge clk);
  endtask

  task automatic run(input string tag, input int ectb, input int ecto, input int ects);
    int edge_n;
    int diffs;
    load_and_reset();
    check({tag, "/rst_done"}, 32'(done), 0);
    check({tag, "/rst_idx"}, 32'(dut.rf1.core[4]), 0);
    @(negedge clk) reset = 1'b1;
    edge_n = 0;
    while (edge_n < 60 && done !== 1'b1) begin
      @(posedge clk); #1;
      edge_n++;
    end
    check({tag, "/latency"}, edge_n, 37);
    check({tag, "/ctb"}, 32'(dut.dm1.core[33]), ectb);
    check({tag, "/cto"}, 32'(dut.dm1.core[34]), ecto);
    check({tag, "/cts"}, 32'(dut.dm1.core[35]), ects);
    diffs = 0;
    for (int k = 0; k <= 32; k++) if (dut.dm1.core[k] !== img[k]) diffs++;
    check({tag, "/src_kept"}, diffs, 0);
    check({tag, "/rf_hi_zero"},
          32'(dut.rf1.core[5] | dut.rf1.core[6] | dut.rf1.core[7]), 0);
    repeat (3) @(posedge clk);
    #1 check({tag, "/done_held"}, 32'(done), 1);
  endtask

  initial begin
    int ectb, ecto, ects;

    // All zero, pattern 00000: every window matches
    for (int k = 0; k < 32; k++) img[k] = 8'h00;
    img[32] = 8'h00;
    run("zeros_p00000", 128, 32, 252);

    // Alternating bits, pattern 10101
    for (int k = 0; k < 32; k++) img[k] = 8'h55;
    img[32] = 8'hA8;
    run("x55_p10101", 64, 32, 126);

    // No match anywhere
    for (int k = 0; k < 32; k++) img[k] = 8'h00;
    img[32] = 8'hF8;
    run("zeros_p11111", 0, 0, 0);

    // Single boundary-only hit between bytes 5 and 6
    img[5] = 8'h0F;
    img[6] = 8'h80;
    run("boundary_only", 0, 0, 1);

    // Byte 31 all ones next to an all-ones pattern byte: boundary suppressed
    for (int k = 0; k < 32; k++) img[k] = 8'h00;
    img[31] = 8'hFF;
    img[32] = 8'hFF;
    run("last_byte", 4, 1, 4);

    // Abort during SCAN, then rerun
    for (int k = 0; k < 32; k++) img[k] = 8'($urandom);
    img[32] = 8'($urandom);
    load_and_reset();
    @(negedge clk) reset = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("abort/done_low", 32'(done), 0);
    check("abort/idx_clear", 32'(dut.rf1.core[4]), 0);
    check("abort/cts_clear", 32'(dut.rf1.core[3]), 0);
    model(ectb, ecto, ects);
    run("abort_rerun", ectb, ecto, ects);

    // Random strings and patterns
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 32; k++) img[k] = 8'($urandom);
      img[32] = 8'($urandom);
      model(ectb, ecto, ects);
      run($sformatf("rand%0d", r), ectb, ecto, ects);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/top_level.md
TOP_LEVEL -- requirements
Module: top_level

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit, a synchronous active-low reset; the block is held idle while low and starts a run when it goes high.
REQ-003 The block SHALL have the port done, output, 1 bit, high when the run is complete, held until the next reset.
REQ-004 The block SHALL have the parameters STR_BYTES = 32 (search-string length in bytes) and MEM_DEPTH = 256 (data-memory bytes).

Function
REQ-005 The block SHALL contain a data memory, instance dm1, holding an array core[0:255] of 8-bit words, with 2 combinational read ports and 1 synchronous write port.
REQ-006 The block SHALL contain a register file, instance rf1, holding an array core[0:7] of 8-bit words.
REQ-007 Memory map SHALL be: core[0..31] is the search string, with byte 0 most significant; core[32][7:3] is the 5-bit pattern P; results go to core[33] = CTB, core[34] = CTO, core[35] = CTS.
REQ-008 CTB SHALL count, over all 32 bytes, the in-byte windows [7:3], [6:2], [5:1] and [4:0] that equal P; range 0..128.
REQ-009 CTO SHALL count the bytes having at least one in-byte window equal to P; range 0..32.
REQ-010 CTS SHALL count the 252 five-bit windows of the 256-bit string that equal P, overlaps allowed.
REQ-011 CTS SHALL equal CTB plus the boundary windows between byte i and byte i+1, for i = 0..30.
REQ-012 The boundary windows SHALL be {b_i[3:0], b_i+1[7]}, {b_i[2:0], b_i+1[7:6]}, {b_i[1:0], b_i+1[7:5]} and {b_i[0], b_i+1[7:4]}.
REQ-013 For byte 31 the boundary windows SHALL be suppressed; core[32] never contributes to any count.
REQ-014 All counters SHALL be 8 bits; maximum values (128, 32, 252) never overflow.
REQ-015 The FSM SHALL have the states IDLE, LDPAT, SCAN, WR_CTB, WR_CTO, WR_CTS and DONE.
REQ-016 IDLE SHALL go to LDPAT on the first edge with reset high.
REQ-017 LDPAT (1 cycle) SHALL load rf1.core[0] <= {3'b0, P}.
REQ-018 SCAN (32 cycles, index i = 0..31 in rf1.core[4]) SHALL evaluate byte i and byte i+1 in one cycle and update rf1.core[1] (CTB), core[2] (CTO) and core[3] (CTS).
REQ-019 WR_CTB, WR_CTO and WR_CTS SHALL each write one result, to core[33], core[34] and core[35] in that order, 1 cycle each.
REQ-020 On entering DONE, done SHALL be registered high; DONE SHALL be absorbing until reset.
REQ-021 Latency SHALL be fixed: done rises on the 37th rising edge after the first edge sampling reset high, independent of data.
REQ-022 The block SHALL write only addresses 33..35; core[0..32] and all other addresses remain unchanged.
REQ-023 rf1.core[5..7] SHALL stay 0.

Reset
REQ-024 While reset is low: state = IDLE, done = 0, rf1.core[0..7] = 0.
REQ-025 Reset SHALL NOT clear dm1, so preloaded memory survives reset.
REQ-026 Reset asserted mid-run SHALL abort at the next edge; a partial result write may remain.
REQ-027 After an aborted run, the next release SHALL restart from LDPAT and overwrite 33..35.
REQ-028 Reset held low for 1 cycle SHALL suffice.

Structure
REQ-029 A shared package SHALL hold: STR_BYTES, MEM_DEPTH, PAT_ADDR = 32, CTB_ADDR = 33, CTO_ADDR = 34, CTS_ADDR = 35, the register indices (R_PAT = 0, R_CTB = 1, R_CTO = 2, R_CTS = 3, R_IDX = 4) and the FSM state enum.
REQ-030 Sub-modules SHALL be data_mem (instance dm1) and reg_file (instance rf1); hierarchical names dm1.core and rf1.core are mandatory.
REQ-031 The window matcher SHALL be combinational logic within top_level.

Verification
REQ-032 Bench SHALL cover: P = 00000, all bytes 0x00 -> CTB = 128, CTO = 32, CTS = 252, done at edge 37.
REQ-033 Bench SHALL cover: P = 10101, all bytes 0x55 -> CTB = 64, CTO = 32, CTS = 126.
REQ-034 Bench SHALL cover: P = 11111, all bytes 0x00 -> CTB = 0, CTO = 0, CTS = 0; core[0..32] unchanged.
REQ-035 Bench SHALL cover: P = 11111, byte 5 = 0x0F, byte 6 = 0x80, others 0 -> CTB = 0, CTO = 0, CTS = 1 (boundary window only).
REQ-036 Bench SHALL cover: reset low at cycle 10 of SCAN, then release -> done low during the abort; the rerun gives correct counts at edge 37.
REQ-037 Bench SHALL cover: 20 runs with random string and pattern -> all three counts match the golden model of REQ-008 to REQ-013.
